// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, ALU/PC/WB selects,
// sequencer states and the decoded-opcode record.
package riscv_pkg;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALU_ITYPE = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_MISC  = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_TRAP = 3'd6
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       is_jmp;
    logic [1:0] alu_op;
    logic       alu_src;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: legality, instruction class and the EX-step ALU controls.
module mc_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  // Map each supported major opcode to its class flags and ALU setup; anything else is illegal.
  always_comb begin
    dec = '{legal: 1'b0, is_ld: 1'b0, is_st: 1'b0, is_br: 1'b0, is_jmp: 1'b0,
            alu_op: ALU_ITYPE, alu_src: 1'b0};
    case (opcode)
      OP_LD: begin
        dec.legal   = 1'b1;
        dec.is_ld   = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
      end
      OP_ST: begin
        dec.legal   = 1'b1;
        dec.is_st   = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
      end
      OP_R: begin
        dec.legal   = 1'b1;
        dec.alu_op  = ALU_RTYPE;
        dec.alu_src = 1'b0;
      end
      OP_BR: begin
        dec.legal   = 1'b1;
        dec.is_br   = 1'b1;
        dec.alu_op  = ALU_MISC;
        dec.alu_src = 1'b0;
      end
      OP_I: begin
        dec.legal   = 1'b1;
        dec.alu_op  = ALU_ITYPE;
        dec.alu_src = 1'b1;
      end
      OP_LUI: begin
        dec.legal   = 1'b1;
        dec.alu_op  = ALU_MISC;
        dec.alu_src = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec.legal   = 1'b1;
        dec.is_jmp  = 1'b1;
        dec.alu_op  = ALU_MISC;
        dec.alu_src = 1'b1;
      end
      default: begin
        dec.legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the shared-memory RV32I datapath, with a
// memory-ready handshake, bus timeout and illegal-opcode trap.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [2:0] state_o
);

  localparam int             TW       = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

  state_t        state_r;
  logic [6:0]    opcode_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [6:0]    dec_in_s;
  dec_t          dec_s;

  // In ID the incoming opcode is judged before it lands in opcode_r.
  assign dec_in_s = (state_r == ST_ID) ? opcode : opcode_r;

  mc_decode u_decode (
    .opcode (dec_in_s),
    .dec    (dec_s)
  );

  // Sequencer state, latched opcode and memory-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      opcode_r  <= 7'd0;
      tmo_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_IF;
          tmo_cnt_r <= '0;
        end
        ST_IF: begin
          if (mem_ready) begin
            state_r <= ST_ID;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r <= ST_TRAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_ID: begin
          opcode_r <= opcode;
          state_r  <= dec_s.legal ? ST_EX : ST_TRAP;
        end
        ST_EX: begin
          tmo_cnt_r <= '0;
          if (dec_s.is_br) begin
            state_r <= ST_IF;
          end else if (dec_s.is_ld || dec_s.is_st) begin
            state_r <= ST_MEM;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            tmo_cnt_r <= '0;
            state_r   <= dec_s.is_st ? ST_IF : ST_WB;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r <= ST_TRAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_WB: begin
          state_r   <= ST_IF;
          tmo_cnt_r <= '0;
        end
        ST_TRAP: begin
          state_r <= ST_TRAP;
        end
        default: begin
          state_r <= ST_TRAP;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and latched opcode class.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALU_ITYPE;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        trap = 1'b0;
      end
      ST_IF: begin
        mem_req = 1'b1;
        iord    = 1'b0;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end else begin
          ir_write = 1'b0;
        end
      end
      ST_ID: begin
        trap = 1'b0;
      end
      ST_EX: begin
        alu_op  = dec_s.alu_op;
        alu_src = dec_s.alu_src;
        if (dec_s.is_br) begin
          pc_write   = zero;
          pc_src     = PC_BRANCH;
          instr_done = 1'b1;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = dec_s.is_st;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        if (mem_ready) begin
          instr_done = dec_s.is_st;
        end else begin
          instr_done = 1'b0;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        if (dec_s.is_ld) begin
          wb_sel = WB_MEM;
        end else if (dec_s.is_jmp) begin
          wb_sel   = WB_LINK;
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end else begin
          wb_sel = WB_ALU;
        end
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b1;
      end
    endcase
  end

  assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks compare the state plus all control
// outputs against hand-computed vectors.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src, reg_write, instr_done, trap;
  logic [1:0] pc_src, alu_op, wb_sel;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [17:0] exp;
  logic [17:0] obs;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, BAD = 7'b1111111;

  // Layout: state | mem_req mem_we iord ir_write pc_write | pc_src | alu_op | alu_src reg_write | wb_sel | instr_done trap
  localparam logic [17:0] V_IDLE     = 18'b000_00000_00_00_00_00_00;
  localparam logic [17:0] V_IF_WAIT  = 18'b001_10000_00_00_00_00_00;
  localparam logic [17:0] V_IF_RDY   = 18'b001_10011_00_00_00_00_00;
  localparam logic [17:0] V_ID       = 18'b010_00000_00_00_00_00_00;
  localparam logic [17:0] V_EX_R     = 18'b011_00000_00_10_00_00_00;
  localparam logic [17:0] V_WB_R     = 18'b101_00000_00_00_01_00_10;
  localparam logic [17:0] V_EX_LDST  = 18'b011_00000_00_01_10_00_00;
  localparam logic [17:0] V_MEM_LD   = 18'b100_10100_00_01_10_00_00;
  localparam logic [17:0] V_MEM_ST   = 18'b100_11100_00_01_10_00_00;
  localparam logic [17:0] V_WB_LD    = 18'b101_00000_00_00_01_01_10;
  localparam logic [17:0] V_EX_BR1   = 18'b011_00001_01_11_00_00_10;
  localparam logic [17:0] V_EX_BR0   = 18'b011_00000_01_11_00_00_10;
  localparam logic [17:0] V_EX_JAL   = 18'b011_00000_00_11_10_00_00;
  localparam logic [17:0] V_WB_JAL   = 18'b101_00001_10_00_01_10_10;
  localparam logic [17:0] V_TRAP     = 18'b110_00000_00_00_00_00_01;

  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op,
                alu_src, reg_write, wb_sel, instr_done, trap};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .instr_done (instr_done),
    .trap       (trap),
    .state_o    (state_o)
  );

  // Drive one cycle's inputs on the falling edge and let the outputs settle.
  task automatic cyc(input logic mr, input logic [6:0] op, input logic z);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    zero      = z;
    #1;
    if (instr_done === 1'b1) done_cnt++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;
    #1;
    exp = V_IDLE; checks++; if (obs !== exp) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp = V_IDLE; checks++; if (obs !== exp) begin failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_rtype;
    test_reset;
    done_cnt = 0;
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_IF_RDY; checks++; if (obs !== exp) begin failures++; $display("FAIL r_if obs=%b exp=%b", obs, exp); end
    cyc(1'b0, RT, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL r_id obs=%b exp=%b", obs, exp); end
    cyc(1'b0, BAD, 1'b0);
    exp = V_EX_R; checks++; if (obs !== exp) begin failures++; $display("FAIL r_ex obs=%b exp=%b", obs, exp); end
    cyc(1'b0, BAD, 1'b0);
    exp = V_WB_R; checks++; if (obs !== exp) begin failures++; $display("FAIL r_wb obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL r_back_if obs=%b exp=%b", obs, exp); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL r_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_load;
    test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 7'd0, 1'b0);
      exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_if_wait%0d obs=%b exp=%b", i, obs, exp); end
    end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_IF_RDY; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_if_rdy obs=%b exp=%b", obs, exp); end
    cyc(1'b0, LD, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_id obs=%b exp=%b", obs, exp); end
    cyc(1'b0, LD, 1'b0);
    exp = V_EX_LDST; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_ex obs=%b exp=%b", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, LD, 1'b0);
      exp = V_MEM_LD; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_mem_wait%0d obs=%b exp=%b", i, obs, exp); end
    end
    cyc(1'b1, LD, 1'b0);
    exp = V_MEM_LD; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_mem_rdy obs=%b exp=%b", obs, exp); end
    cyc(1'b0, LD, 1'b0);
    exp = V_WB_LD; checks++; if (obs !== exp) begin failures++; $display("FAIL ld_wb obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_branch;
    test_reset;
    cyc(1'b1, 7'd0, 1'b0);
    cyc(1'b0, BR, 1'b0);
    cyc(1'b0, 7'd0, 1'b1);
    exp = V_EX_BR1; checks++; if (obs !== exp) begin failures++; $display("FAIL br_taken obs=%b exp=%b", obs, exp); end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_IF_RDY; checks++; if (obs !== exp) begin failures++; $display("FAIL br_back_if obs=%b exp=%b", obs, exp); end
    cyc(1'b0, BR, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL br_id obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_EX_BR0; checks++; if (obs !== exp) begin failures++; $display("FAIL br_not_taken obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL br_nt_back_if obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_jal;
    test_reset;
    cyc(1'b1, 7'd0, 1'b0);
    cyc(1'b1, JAL, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL jal_id obs=%b exp=%b", obs, exp); end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_EX_JAL; checks++; if (obs !== exp) begin failures++; $display("FAIL jal_ex obs=%b exp=%b", obs, exp); end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_WB_JAL; checks++; if (obs !== exp) begin failures++; $display("FAIL jal_wb obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL jal_back_if obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_illegal;
    test_reset;
    cyc(1'b1, 7'd0, 1'b0);
    cyc(1'b0, BAD, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL ill_id obs=%b exp=%b", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, RT, 1'b0);
      exp = V_TRAP; checks++; if (obs !== exp) begin failures++; $display("FAIL ill_trap%0d obs=%b exp=%b", i, obs, exp); end
    end
    test_reset;
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL ill_restart obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_timeout;
    test_reset;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 7'd0, 1'b0);
      exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL tmo_if%0d obs=%b exp=%b", i, obs, exp); end
    end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_TRAP; checks++; if (obs !== exp) begin failures++; $display("FAIL tmo_trap obs=%b exp=%b", obs, exp); end
    test_reset;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 7'd0, 1'b0);
    end
    cyc(1'b1, 7'd0, 1'b0);
    exp = V_IF_RDY; checks++; if (obs !== exp) begin failures++; $display("FAIL tmo_last_rdy obs=%b exp=%b", obs, exp); end
    cyc(1'b0, RT, 1'b0);
    exp = V_ID; checks++; if (obs !== exp) begin failures++; $display("FAIL tmo_no_trap obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_reset_in_mem;
    test_reset;
    cyc(1'b1, 7'd0, 1'b0);
    cyc(1'b0, ST, 1'b0);
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_EX_LDST; checks++; if (obs !== exp) begin failures++; $display("FAIL st_ex obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_MEM_ST; checks++; if (obs !== exp) begin failures++; $display("FAIL st_mem obs=%b exp=%b", obs, exp); end
    #2;
    rst_n = 1'b0;
    #1;
    exp = V_IDLE; checks++; if (obs !== exp) begin failures++; $display("FAIL st_async_rst obs=%b exp=%b", obs, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp = V_IDLE; checks++; if (obs !== exp) begin failures++; $display("FAIL st_rst_idle obs=%b exp=%b", obs, exp); end
    cyc(1'b0, 7'd0, 1'b0);
    exp = V_IF_WAIT; checks++; if (obs !== exp) begin failures++; $display("FAIL st_restart_if obs=%b exp=%b", obs, exp); end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_load;
    test_branch;
    test_jal;
    test_illegal;
    test_timeout;
    test_reset_in_mem;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
